// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: splits one DATA_W read/write request into DATA_W/BUS_W beats
// on a narrower bidirectional memory bus. The beat address auto-increments by
// BUS_W/8 bytes and each beat waits for mem_ack.
// Optional feature macro: BIU_TIMEOUT_EN. When defined, an ACCESS stalled
// for WAIT_MAX cycles without mem_ack is aborted and reported with rsp_err.
module bus_xfer_seq #(
    parameter int DATA_W   = 64,
    parameter int BUS_W    = 32,
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    inout  wire  [BUS_W-1:0]  Bus_data,
    output logic              busy
);

    localparam int BEATS  = DATA_W / BUS_W;
    localparam int STRIDE = BUS_W / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q;
    logic [ADDR_W-1:0]   base_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                we_q;
    logic                last_beat;
    logic                timeout;
    logic                drive_bus;

    assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

`ifdef BIU_TIMEOUT_EN
    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX + 1) : 1;
    logic [CNT_W-1:0] wait_q;
    logic             err_q;

    // Abort on the cycle that would bring the stall count up to WAIT_MAX.
    assign timeout = (state_q == ACCESS) && !mem_ack &&
                     (wait_q == CNT_W'(WAIT_MAX - 1));

    // Stall counter: zero outside ACCESS and after every ack, counts idle beats.
    always_ff @(posedge Clk) begin
        if (Reset || state_q != ACCESS || mem_ack)
            wait_q <= '0;
        else
            wait_q <= wait_q + 1'b1;
    end

    // Error flag: cleared when a request is accepted, set by an abort.
    always_ff @(posedge Clk) begin
        if (Reset)
            err_q <= 1'b0;
        else if (state_q == IDLE && req_valid)
            err_q <= 1'b0;
        else if (timeout)
            err_q <= 1'b1;
    end

    assign rsp_err = (state_q == RESP) && err_q;
`else
    assign timeout = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        mem_cs    = 1'b0;
        mem_we    = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        mem_addr  = '0;
        case (state_q)
            IDLE: begin
                busy      = 1'b0;
                req_ready = !Reset;
                if (req_valid)
                    state_d = ACCESS;
            end
            ACCESS: begin
                mem_cs   = 1'b1;
                mem_we   = we_q;
                mem_addr = base_q + ADDR_W'(beat_q) * ADDR_W'(STRIDE);
                if ((mem_ack && last_beat) || timeout)
                    state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat counter and read-data capture.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            beat_q  <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    base_q  <= req_addr;
                    wdata_q <= req_wdata;
                    we_q    <= req_we;
                    rdata_q <= '0;
                    beat_q  <= '0;
                end
                ACCESS: if (mem_ack) begin
                    if (!we_q)
                        rdata_q[beat_q*BUS_W +: BUS_W] <= Bus_data;
                    if (!last_beat)
                        beat_q <= beat_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Drive the bus only while a write beat is in flight.
    assign drive_bus = (state_q == ACCESS) && we_q;
    assign Bus_data  = drive_bus ? wdata_q[beat_q*BUS_W +: BUS_W] : {BUS_W{1'bz}};
    assign rsp_rdata = rdata_q;

endmodule
